// File: rtl/ds1_pkg.sv
// Shared DS1 justification definitions: frame length, default thresholds, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents:
//   DS1_FRAME_LEN    - read cycles per 193-bit DS1 frame
//   DS1_AW           - default elastic store address width (depth 2**AW bits)
//   DS1_HI_THR       - default fill at or above which a sub request is raised
//   DS1_LO_THR       - default fill at or below which an add request is raised
//   DS1_HOLDOFF      - default number of frames suppressed after an ack
//   just_state_e     - justification FSM state encoding
package ds1_pkg;

  localparam int DS1_FRAME_LEN = 193;
  localparam int DS1_AW        = 4;
  localparam int DS1_HI_THR    = 12;
  localparam int DS1_LO_THR    = 4;
  localparam int DS1_HOLDOFF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_SUB  = 2'd2,
    ST_HOLD = 2'd3
  } just_state_e;

endpackage

// File: rtl/ds1_bit_store.sv
// DS1 bit elastic store: circular 2**AW x 1 buffer with occupancy and over/underflow flags.
// Latency: 1 cycle from accepted rd_en to rd_bit/rd_valid.
// Backpressure: none; writes to a full store are dropped (ovf), reads of an empty store return nothing (unf).
//
// Ports:
//   ds1ck, reset      - clock, synchronous active-high reset
//   wr_en, wr_bit     - write strobe and data bit
//   rd_en             - read strobe
//   rd_bit, rd_valid  - registered read data and its qualifier
//   fill              - occupancy 0..2**AW, straight from the pointers
//   ovf, unf          - one-cycle pulses for a dropped write / empty read
module ds1_bit_store
  import ds1_pkg::*;
#(
  parameter int AW = DS1_AW
) (
  input  logic        ds1ck,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        wr_bit,
  input  logic        rd_en,
  output logic        rd_bit,
  output logic        rd_valid,
  output logic [AW:0] fill,
  output logic        ovf,
  output logic        unf
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic             rd_bit_q, rd_bit_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic rd_acc;
  logic wr_acc;

  assign fill = wr_ptr_q - rd_ptr_q;

  // An empty store cannot serve a read even if a write lands the same cycle,
  // but a full store can take a write when a read frees a slot that cycle.
  assign rd_acc = rd_en && (fill != '0);
  assign wr_acc = wr_en && ((fill != DEPTH_L) || rd_acc);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    rd_bit_d   = 1'b0;
    rd_valid_d = 1'b0;
    ovf_d      = wr_en && !wr_acc;
    unf_d      = rd_en && !rd_acc;

    if (rd_acc) begin
      // On a full store with a same-cycle write both pointers address the
      // same slot; the old bit is read here before mem_q is overwritten.
      rd_bit_d   = mem_q[rd_ptr_q[AW-1:0]];
      rd_valid_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + 1'b1;
    end

    if (wr_acc) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_bit;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge ds1ck) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_q      <= '0;
      rd_bit_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
      rd_bit_q   <= rd_bit_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign rd_bit   = rd_bit_q;
  assign rd_valid = rd_valid_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule

// File: rtl/ds1_just_ctl.sv
// DS1 elastic store plus once-per-frame add/sub justification request generator.
// Latency: read data 1 cycle after rd_en; request 1 cycle after the frame_sync cycle.
// Backpressure: requests are held until just_ack, then suppressed for HOLDOFF frames.
//
// Ports:
//   ds1ck, reset          - clock, synchronous active-high reset
//   wr_en, wr_bit         - line-side write strobe and data bit
//   rd_en                 - mapper read strobe, also advances the frame counter
//   rd_bit, rd_valid      - registered read data and qualifier
//   fill                  - store occupancy 0..2**AW
//   frame_sync            - one-cycle pulse after the frame-wrapping rd_en
//   add_req, sub_req      - justification requests toward the VT1.5 mapper
//   just_ack              - mapper accepted the pending request
//   ovf, unf              - dropped-write / empty-read pulses
module ds1_just_ctl
  import ds1_pkg::*;
#(
  parameter int AW        = DS1_AW,
  parameter int FRAME_LEN = DS1_FRAME_LEN,
  parameter int HI_THR    = DS1_HI_THR,
  parameter int LO_THR    = DS1_LO_THR,
  parameter int HOLDOFF   = DS1_HOLDOFF
) (
  input  logic        ds1ck,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        wr_bit,
  input  logic        rd_en,
  output logic        rd_bit,
  output logic        rd_valid,
  output logic [AW:0] fill,
  output logic        frame_sync,
  output logic        add_req,
  output logic        sub_req,
  input  logic        just_ack,
  output logic        ovf,
  output logic        unf
);

  localparam int FCW = $clog2(FRAME_LEN);
  localparam int HCW = $clog2(HOLDOFF + 1);

  localparam logic [FCW-1:0] FC_LAST   = FCW'(FRAME_LEN - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLDOFF - 1);
  localparam logic [AW:0]    HI_L      = (AW + 1)'(HI_THR);
  localparam logic [AW:0]    LO_L      = (AW + 1)'(LO_THR);

  just_state_e      state_q, state_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic             frame_sync_q, frame_sync_d;

  ds1_bit_store #(
    .AW (AW)
  ) u_store (
    .ds1ck    (ds1ck),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_bit   (wr_bit),
    .rd_en    (rd_en),
    .rd_bit   (rd_bit),
    .rd_valid (rd_valid),
    .fill     (fill),
    .ovf      (ovf),
    .unf      (unf)
  );

  // Frame counter follows every rd_en, underflow reads included, so the
  // frame boundary stays locked to the mapper's read timing.
  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    frame_sync_d = 1'b0;
    if (rd_en) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d  = '0;
        frame_sync_d = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // The IDLE decision looks at fill during the frame_sync cycle itself.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_sync_q) begin
          if (fill >= HI_L) begin
            state_d = ST_SUB;
          end else if (fill <= LO_L) begin
            state_d = ST_ADD;
          end
        end
      end
      ST_ADD, ST_SUB: begin
        if (just_ack) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (frame_sync_q) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge ds1ck) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      frame_sync_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  // Requests decode straight from the state register, so they are mutually
  // exclusive by construction and drop on the same edge that takes the ack.
  assign add_req    = (state_q == ST_ADD);
  assign sub_req    = (state_q == ST_SUB);
  assign frame_sync = frame_sync_q;

endmodule
